// File: rtl/gsim_pkg.sv
// Shared types and constants for the Gauss-Seidel sequencer: state encoding,
// matrix geometry and datapath widths.
package gsim_pkg;

    localparam int N_ROW        = 16;
    localparam int ROWS_PER_MTX = 17;
    localparam int MEM_AW       = 10;
    localparam int X_AW         = 9;
    localparam int ROW_W        = 256;
    localparam int RES_W        = 32;
    localparam int MTX_W        = 5;
    localparam int CNT_W        = 5;
    localparam int K_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RUN   = 3'd2,
        ST_XOUT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } gsim_state_e;

    // Rows of a matrix are fetched top address first: base+last down to base.
    function automatic logic [MEM_AW-1:0] fetch_addr(input logic [MEM_AW-1:0] base,
                                                     input logic [CNT_W-1:0]  last,
                                                     input logic [CNT_W-1:0]  iss);
        return base + {{(MEM_AW-CNT_W){1'b0}}, last} - {{(MEM_AW-CNT_W){1'b0}}, iss};
    endfunction

endpackage

// File: rtl/gsim_if.sv
// Matrix-memory read handshake between the sequencer (master) and the memory (slave).
interface gsim_if;

    logic                         o_mem_rreq;
    logic [gsim_pkg::MEM_AW-1:0]  o_mem_addr;
    logic                         i_mem_rrdy;
    logic [gsim_pkg::ROW_W-1:0]   i_mem_dout;
    logic                         i_mem_dout_vld;

    modport master (
        output o_mem_rreq,
        output o_mem_addr,
        input  i_mem_rrdy,
        input  i_mem_dout,
        input  i_mem_dout_vld
    );

    modport slave (
        input  o_mem_rreq,
        input  o_mem_addr,
        output i_mem_rrdy,
        output i_mem_dout,
        output i_mem_dout_vld
    );

endinterface

// File: rtl/gsim_x_writer.sv
// Result copy-out: walks the engine result port and writes x values with a
// one-cycle read-to-write pipeline, flagging the last write back to the FSM.
module gsim_x_writer #(
    parameter int N_ROW = gsim_pkg::N_ROW
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        en,
    input  logic [gsim_pkg::MTX_W-1:0]  mtx,
    output logic [gsim_pkg::K_W-1:0]    res_raddr,
    input  logic [gsim_pkg::RES_W-1:0]  res_rdata,
    output logic                        x_wen,
    output logic [gsim_pkg::X_AW-1:0]   x_addr,
    output logic [gsim_pkg::RES_W-1:0]  x_data,
    output logic                        done
);
    import gsim_pkg::*;

    localparam logic [K_W-1:0] LAST_K_C = K_W'(N_ROW - 1);

    logic [K_W-1:0]  k_r;
    logic            issued_r;
    logic            wen_r;
    logic [X_AW-1:0] addr_r;
    logic            done_r;

    // Read counter and write-side pipeline; everything clears whenever XOUT is left.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k_r      <= {K_W{1'b0}};
            issued_r <= 1'b0;
            wen_r    <= 1'b0;
            addr_r   <= {X_AW{1'b0}};
            done_r   <= 1'b0;
        end else if (!en) begin
            k_r      <= {K_W{1'b0}};
            issued_r <= 1'b0;
            wen_r    <= 1'b0;
            addr_r   <= {X_AW{1'b0}};
            done_r   <= 1'b0;
        end else begin
            wen_r  <= !issued_r;
            addr_r <= issued_r ? {X_AW{1'b0}} : {mtx, k_r};
            done_r <= !issued_r && (k_r == LAST_K_C);
            if (!issued_r) begin
                k_r      <= (k_r == LAST_K_C) ? {K_W{1'b0}} : k_r + 4'd1;
                issued_r <= (k_r == LAST_K_C);
            end else begin
                k_r      <= k_r;
                issued_r <= issued_r;
            end
        end
    end

    assign res_raddr = k_r;
    assign x_wen     = wen_r;
    assign x_addr    = addr_r;
    // Result RAM data lands in the write cycle, so it passes straight through.
    assign x_data    = wen_r ? res_rdata : {RES_W{1'b0}};
    assign done      = done_r;

endmodule

// File: rtl/gsim_seq.sv
// Top-level sequencer: per matrix, fetch 17 rows, load the engine, run it,
// then copy the 16 solved x values out.
module gsim_seq #(
    parameter int N_ROW        = gsim_pkg::N_ROW,
    parameter int ROWS_PER_MTX = gsim_pkg::ROWS_PER_MTX,
    parameter int MAX_OUTST    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_module_en,
    input  logic [4:0]                  i_matrix_num,
    output logic                        o_proc_done,
    gsim_if.master                      mem,
    output logic                        o_ld_vld,
    output logic [4:0]                  o_ld_idx,
    output logic [gsim_pkg::ROW_W-1:0]  o_ld_data,
    output logic                        o_eng_start,
    input  logic                        i_eng_done,
    output logic [3:0]                  o_res_raddr,
    input  logic [gsim_pkg::RES_W-1:0]  i_res_rdata,
    output logic                        o_x_wen,
    output logic [gsim_pkg::X_AW-1:0]   o_x_addr,
    output logic [gsim_pkg::RES_W-1:0]  o_x_data
);
    import gsim_pkg::*;

    localparam logic [CNT_W-1:0]  ROWS_C       = CNT_W'(ROWS_PER_MTX);
    localparam logic [CNT_W-1:0]  LAST_IDX_C   = CNT_W'(ROWS_PER_MTX - 1);
    localparam logic [CNT_W-1:0]  MAX_OUTST_C  = CNT_W'(MAX_OUTST);
    localparam logic [MEM_AW-1:0] MTX_STRIDE_C = MEM_AW'(ROWS_PER_MTX);

    gsim_state_e       state_r;
    logic [MTX_W-1:0]  m_r;
    logic [MTX_W-1:0]  num_r;
    logic [MEM_AW-1:0] base_r;
    logic [CNT_W-1:0]  iss_r;
    logic [CNT_W-1:0]  ret_r;
    logic [CNT_W-1:0]  outst_s;
    logic              rreq_s;
    logic              acc_s;
    logic              rtn_s;
    logic              x_done_s;
    logic              ld_vld_r;
    logic [CNT_W-1:0]  ld_idx_r;
    logic [ROW_W-1:0]  ld_data_r;
    logic              eng_start_r;
    logic              proc_done_r;

    assign outst_s = iss_r - ret_r;
    assign rreq_s  = (state_r == ST_FETCH) && (iss_r < ROWS_C) && (outst_s < MAX_OUTST_C);
    assign acc_s   = rreq_s && mem.i_mem_rrdy;
    // A return with nothing outstanding is stale (e.g. from before a reset) and is dropped.
    assign rtn_s   = mem.i_mem_dout_vld && (outst_s != {CNT_W{1'b0}});

    assign mem.o_mem_rreq = rreq_s;
    assign mem.o_mem_addr = (state_r == ST_FETCH) ? fetch_addr(base_r, LAST_IDX_C, iss_r)
                                                  : {MEM_AW{1'b0}};

    // Register each accepted return and forward it to the engine load port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ld_vld_r  <= 1'b0;
            ld_idx_r  <= {CNT_W{1'b0}};
            ld_data_r <= {ROW_W{1'b0}};
        end else begin
            ld_vld_r  <= rtn_s;
            ld_idx_r  <= rtn_s ? ret_r : {CNT_W{1'b0}};
            ld_data_r <= rtn_s ? mem.i_mem_dout : {ROW_W{1'b0}};
        end
    end

    // Main sequencer FSM with fetch counters and registered strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            m_r         <= {MTX_W{1'b0}};
            num_r       <= {MTX_W{1'b0}};
            base_r      <= {MEM_AW{1'b0}};
            iss_r       <= {CNT_W{1'b0}};
            ret_r       <= {CNT_W{1'b0}};
            eng_start_r <= 1'b0;
            proc_done_r <= 1'b0;
        end else begin
            eng_start_r <= 1'b0;
            proc_done_r <= 1'b0;
            iss_r       <= iss_r + {{(CNT_W-1){1'b0}}, acc_s};
            ret_r       <= ret_r + {{(CNT_W-1){1'b0}}, rtn_s};
            case (state_r)
                ST_IDLE: begin
                    if (i_module_en) begin
                        num_r   <= i_matrix_num;
                        m_r     <= {MTX_W{1'b0}};
                        base_r  <= {MEM_AW{1'b0}};
                        iss_r   <= {CNT_W{1'b0}};
                        ret_r   <= {CNT_W{1'b0}};
                        state_r <= (i_matrix_num == 5'd0) ? ST_DONE : ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (ld_vld_r && (ld_idx_r == LAST_IDX_C)) begin
                        state_r     <= ST_RUN;
                        eng_start_r <= 1'b1;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_RUN: begin
                    state_r <= i_eng_done ? ST_XOUT : ST_RUN;
                end
                ST_XOUT: begin
                    state_r <= x_done_s ? ST_NEXT : ST_XOUT;
                end
                ST_NEXT: begin
                    m_r     <= m_r + 5'd1;
                    base_r  <= base_r + MTX_STRIDE_C;
                    iss_r   <= {CNT_W{1'b0}};
                    ret_r   <= {CNT_W{1'b0}};
                    state_r <= (({1'b0, m_r} + 6'd1) < {1'b0, num_r}) ? ST_FETCH : ST_DONE;
                end
                ST_DONE: begin
                    proc_done_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    gsim_x_writer #(
        .N_ROW (N_ROW)
    ) u_x_writer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .en        (state_r == ST_XOUT),
        .mtx       (m_r),
        .res_raddr (o_res_raddr),
        .res_rdata (i_res_rdata),
        .x_wen     (o_x_wen),
        .x_addr    (o_x_addr),
        .x_data    (o_x_data),
        .done      (x_done_s)
    );

    assign o_ld_vld    = ld_vld_r;
    assign o_ld_idx    = ld_idx_r;
    assign o_ld_data   = ld_data_r;
    assign o_eng_start = eng_start_r;
    assign o_proc_done = proc_done_r;

endmodule

// File: tb/tb_gsim_seq.sv
// Directed bench for gsim_seq: scenario table plus reset / zero-count sequences,
// with a latency-configurable memory model and a result-RAM model.
module tb_gsim_seq;
    import gsim_pkg::*;

    localparam int MAXO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [4:0]   num;
    logic         proc_done;
    logic         ld_vld;
    logic [4:0]   ld_idx;
    logic [255:0] ld_data;
    logic         eng_start;
    logic         eng_done;
    logic [3:0]   res_raddr;
    logic [31:0]  res_rdata;
    logic         x_wen;
    logic [8:0]   x_addr;
    logic [31:0]  x_data;

    gsim_if mem_if ();

    gsim_seq #(.N_ROW(16), .ROWS_PER_MTX(17), .MAX_OUTST(MAXO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_module_en(en), .i_matrix_num(num),
        .o_proc_done(proc_done), .mem(mem_if),
        .o_ld_vld(ld_vld), .o_ld_idx(ld_idx), .o_ld_data(ld_data),
        .o_eng_start(eng_start), .i_eng_done(eng_done),
        .o_res_raddr(res_raddr), .i_res_rdata(res_rdata),
        .o_x_wen(x_wen), .o_x_addr(x_addr), .o_x_data(x_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] addr; int due; } rd_t;
    typedef struct {
        int num; int lat; bit rnd;
        int exp_starts; int exp_loads; int exp_wr; int exp_maxq; int exp_stall;
    } scen_t;

    rd_t q[$];
    int n_checks = 0, n_errors = 0;
    int cyc = 0, lat = 1, done_due = -1, edone_cyc = -100, last_wr = -100, ld16_cyc = -100;
    int acc_m, acc_i, ld_m, ld_i, n_acc, n_ld, n_start, n_wr, n_done, n_rreq, max_q, stall_seen;
    int stale_cnt = 0;
    bit rrdy_rand = 1'b0, rrdy_off = 1'b0, exp_ld = 1'b0;
    logic [3:0] prev_raddr = 4'd0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] mdata(input logic [9:0] a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = {a, 6'(i), 16'hBEEF};
        return d;
    endfunction

    function automatic logic [31:0] resf(input int k, input int mtx);
        return 32'h5EED_0000 + 32'(mtx) * 32'd256 + 32'(k) * 32'd7 + 32'd1;
    endfunction

    task automatic clear_model();
        q.delete();
        acc_m = 0; acc_i = 0; ld_m = 0; ld_i = 0; n_acc = 0; n_ld = 0; n_start = 0;
        n_wr = 0; n_done = 0; n_rreq = 0; max_q = 0; stall_seen = 0; stale_cnt = 0;
        done_due = -1; exp_ld = 1'b0;
    endtask

    // One clock: drive inputs for the new cycle, then sample and check the DUT.
    task automatic tick();
        int qs;
        bit ret_now;
        int ew;
        @(posedge clk);
        #1;
        cyc++;
        res_rdata = resf(int'(prev_raddr), (n_start > 0) ? n_start - 1 : 0);
        prev_raddr = res_raddr;
        mem_if.i_mem_rrdy = rrdy_off ? 1'b0 : (rrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        qs = q.size();
        ret_now = 1'b0;
        if (qs > 0 && q[0].due <= cyc) begin
            mem_if.i_mem_dout_vld = 1'b1;
            mem_if.i_mem_dout = mdata(q[0].addr);
            void'(q.pop_front());
            if (stale_cnt > 0) stale_cnt--;
            else ret_now = rst_n;
        end else begin
            mem_if.i_mem_dout_vld = 1'b0;
            mem_if.i_mem_dout = '0;
        end
        eng_done = (cyc == done_due);
        if (eng_done) edone_cyc = cyc;
        #1;
        if (qs > max_q) max_q = qs;
        if (mem_if.o_mem_rreq) begin
            n_rreq++;
            check("outst limit", 256'(qs < MAXO), 256'(1));
        end else if (qs == MAXO) begin
            stall_seen = 1;
        end
        if (mem_if.o_mem_rreq && mem_if.i_mem_rrdy) begin
            check("mem addr", 256'(mem_if.o_mem_addr), 256'(17 * acc_m + 16 - acc_i));
            q.push_back('{addr: mem_if.o_mem_addr, due: cyc + lat});
            n_acc++;
            acc_i++;
            if (acc_i == 17) begin acc_i = 0; acc_m++; end
        end
        check("ld_vld", 256'(ld_vld), 256'(exp_ld));
        exp_ld = ret_now;
        if (ld_vld) begin
            check("ld_idx", 256'(ld_idx), 256'(ld_i));
            check("ld_data", ld_data, mdata(10'(17 * ld_m + 16 - ld_i)));
            if (ld_i == 16) ld16_cyc = cyc;
            n_ld++;
            ld_i++;
            if (ld_i == 17) begin ld_i = 0; ld_m++; end
        end
        if (eng_start) begin
            check("start timing", 256'(cyc), 256'(ld16_cyc + 1));
            n_start++;
            done_due = cyc + 3;
        end
        if (x_wen) begin
            ew = n_wr;
            check("x_addr", 256'(x_addr), 256'(ew));
            check("x_data", 256'(x_data), 256'(resf(ew % 16, ew / 16)));
            if (ew % 16 == 0) check("x first write timing", 256'(cyc), 256'(edone_cyc + 2));
            else check("x write spacing", 256'(cyc), 256'(last_wr + 1));
            last_wr = cyc;
            n_wr++;
        end
        if (proc_done) n_done++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " proc_done"}, 256'(proc_done), 256'(0));
        check({tag, " rreq"}, 256'(mem_if.o_mem_rreq), 256'(0));
        check({tag, " mem_addr"}, 256'(mem_if.o_mem_addr), 256'(0));
        check({tag, " ld_vld"}, 256'(ld_vld), 256'(0));
        check({tag, " ld_idx"}, 256'(ld_idx), 256'(0));
        check({tag, " ld_data"}, ld_data, 256'(0));
        check({tag, " eng_start"}, 256'(eng_start), 256'(0));
        check({tag, " res_raddr"}, 256'(res_raddr), 256'(0));
        check({tag, " x_wen"}, 256'(x_wen), 256'(0));
        check({tag, " x_addr"}, 256'(x_addr), 256'(0));
        check({tag, " x_data"}, 256'(x_data), 256'(0));
    endtask

    task automatic run_scenario(input scen_t s);
        clear_model();
        lat = s.lat;
        rrdy_rand = s.rnd;
        num = 5'(s.num);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("first rreq", 256'(mem_if.o_mem_rreq), 256'(1));
        check("first addr", 256'(mem_if.o_mem_addr), 256'(16));
        for (int c = 0; c < 3000 && n_done == 0; c++) begin
            en = (c == 5);
            tick();
        end
        en = 1'b0;
        repeat (3) tick();
        check("proc_done count", 256'(n_done), 256'(1));
        check("engine starts", 256'(n_start), 256'(s.exp_starts));
        check("loads", 256'(n_ld), 256'(s.exp_loads));
        check("x writes", 256'(n_wr), 256'(s.exp_wr));
        check("accepts", 256'(n_acc), 256'(s.exp_loads));
        if (s.exp_maxq >= 0) check("max outstanding", 256'(max_q), 256'(s.exp_maxq));
        if (s.exp_stall >= 0) check("full stall seen", 256'(stall_seen), 256'(s.exp_stall));
    endtask

    scen_t sc[4];

    initial begin
        sc[0] = '{num: 1, lat: 1, rnd: 1'b0, exp_starts: 1, exp_loads: 17, exp_wr: 16, exp_maxq: 1, exp_stall: 0};
        sc[1] = '{num: 1, lat: 6, rnd: 1'b0, exp_starts: 1, exp_loads: 17, exp_wr: 16, exp_maxq: 4, exp_stall: 1};
        sc[2] = '{num: 1, lat: 2, rnd: 1'b1, exp_starts: 1, exp_loads: 17, exp_wr: 16, exp_maxq: -1, exp_stall: -1};
        sc[3] = '{num: 3, lat: 3, rnd: 1'b0, exp_starts: 3, exp_loads: 51, exp_wr: 48, exp_maxq: 3, exp_stall: 0};

        rst_n = 1'b0; en = 1'b0; num = 5'd0; eng_done = 1'b0; res_rdata = 32'd0;
        mem_if.i_mem_rrdy = 1'b0; mem_if.i_mem_dout_vld = 1'b0; mem_if.i_mem_dout = '0;
        clear_model();
        repeat (2) tick();
        check_zero("in reset");
        rst_n = 1'b1;
        tick();
        check_zero("idle");

        for (int s = 0; s < 4; s++) run_scenario(sc[s]);

        // Zero matrices: straight to DONE, pulse two cycles after the start.
        clear_model();
        num = 5'd0;
        en = 1'b1;
        tick();
        en = 1'b0;
        check("num0 done t+1", 256'(proc_done), 256'(0));
        tick();
        check("num0 done t+2", 256'(proc_done), 256'(1));
        tick();
        check("num0 done t+3", 256'(proc_done), 256'(0));
        check("num0 rreq", 256'(n_rreq), 256'(0));
        check("num0 writes", 256'(n_wr), 256'(0));

        // Reset during FETCH with two reads in flight; their late returns must be dropped.
        clear_model();
        lat = 6; rrdy_rand = 1'b0; num = 5'd1;
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int c = 0; c < 20 && n_acc < 2; c++) tick();
        rrdy_off = 1'b1;
        tick();
        check("accepts before reset", 256'(n_acc), 256'(2));
        stale_cnt = q.size();
        exp_ld = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("mid reset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("loads after reset", 256'(n_ld), 256'(0));
        check("returns drained", 256'(q.size()), 256'(0));
        rrdy_off = 1'b0;
        run_scenario(sc[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
